// File: rtl/matmul_loader.sv
// matmul_loader: streams an X then a Y matrix into BRAMs, starts the engine, waits for done.
module matmul_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int VECTOR_SIZE = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_din,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  y_wr_en,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic                  busy,
  output logic [15:0]           pair_count
);
  localparam logic [1:0] LOAD_X = 2'd0, LOAD_Y = 2'd1, START = 2'd2, WAIT = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_SIZE * VECTOR_SIZE - 1);
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, x_addr_q, y_addr_q;
  logic [DATA_WIDTH-1:0] x_din_q, y_din_q;
  logic x_wr_q, y_wr_q, done_q;
  logic [15:0] pair_q;
  logic acc, last, rise, acc_x, acc_y;
  assign in_ready = state_q == LOAD_X || state_q == LOAD_Y;
  assign busy = !in_ready;
  assign mm_start = state_q == START;
  assign acc = in_valid && in_ready;
  assign acc_x = acc && state_q == LOAD_X;
  assign acc_y = acc && state_q == LOAD_Y;
  assign last = cnt_q == LAST;
  // only a fresh rising edge of done ends WAIT; a level left high from the last run does not
  assign rise = mm_done && !done_q;
  always_comb begin
    cnt_d = acc ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d = state_q == LOAD_X ? (acc && last ? LOAD_Y : LOAD_X) :
              state_q == LOAD_Y ? (acc && last ? START : LOAD_Y) :
              state_q == START  ? WAIT : (rise ? LOAD_X : WAIT);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LOAD_X;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      pair_q   <= '0;
      x_wr_q   <= 1'b0;
      y_wr_q   <= 1'b0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      x_din_q  <= '0;
      y_din_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= mm_done;
      x_wr_q  <= acc_x;
      y_wr_q  <= acc_y;
      if (acc_x) begin
        x_addr_q <= cnt_q;
        x_din_q  <= in_din;
      end
      if (acc_y) begin
        y_addr_q <= cnt_q;
        y_din_q  <= in_din;
      end
      if (state_q == WAIT && rise) pair_q <= pair_q + 16'd1;
    end
  end
  assign x_wr_en = x_wr_q;
  assign y_wr_en = y_wr_q;
  assign x_addr = x_addr_q;
  assign y_addr = y_addr_q;
  assign x_din = x_din_q;
  assign y_din = y_din_q;
  assign pair_count = pair_q;
endmodule

// File: tb/tb_matmul_loader.sv
// tb_matmul_loader: directed/random streams on a 4x4 loader against a word-index model, plus a 64x64 sweep.
module tb_matmul_loader;
  localparam int N = 4, NN = N * N;
  logic clock = 0, reset = 1;
  logic [31:0] in_din = 0, x_din, y_din;
  logic in_valid = 0, in_ready, x_wr_en, y_wr_en, mm_start, mm_done = 0, busy;
  logic [11:0] x_addr, y_addr;
  logic [15:0] pair_count;
  logic [31:0] b_din = 0, b_x_din, b_y_din;
  logic b_valid = 0, b_ready, b_x_wr_en, b_y_wr_en, b_start, b_busy;
  logic [11:0] b_x_addr, b_y_addr;
  logic [15:0] b_pairs;
  int total = 0, passed = 0, failed = 0;
  int k = 0, ph = 0, pairs = 0, starts = 0;
  logic pdone = 0, ewx = 0, ewy = 0;
  logic [11:0] lxa = 0, lya = 0;
  logic [31:0] lxd = 0, lyd = 0;

  always #5 clock = ~clock;

  matmul_loader #(.VECTOR_SIZE(N)) dut (
    .clock(clock), .reset(reset), .in_din(in_din), .in_valid(in_valid), .in_ready(in_ready),
    .x_din(x_din), .x_addr(x_addr), .x_wr_en(x_wr_en), .y_din(y_din), .y_addr(y_addr),
    .y_wr_en(y_wr_en), .mm_start(mm_start), .mm_done(mm_done), .busy(busy), .pair_count(pair_count));

  matmul_loader big (
    .clock(clock), .reset(reset), .in_din(b_din), .in_valid(b_valid), .in_ready(b_ready),
    .x_din(b_x_din), .x_addr(b_x_addr), .x_wr_en(b_x_wr_en), .y_din(b_y_din), .y_addr(b_y_addr),
    .y_wr_en(b_y_wr_en), .mm_start(b_start), .mm_done(1'b0), .busy(b_busy), .pair_count(b_pairs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: k counts words of the current pair (first NN go to X, next NN to Y);
  // ph is 0 loading, 1 start cycle, 2 waiting for a new done edge.
  task automatic step(input logic v, input logic [31:0] d, input logic dn, input logic rs);
    in_valid = v; in_din = d; mm_done = dn; reset = rs;
    @(posedge clock); #1;
    ewx = 0; ewy = 0;
    if (rs) begin
      k = 0; ph = 0; pairs = 0; pdone = 0;
      lxa = 0; lya = 0; lxd = 0; lyd = 0;
    end else begin
      if (ph == 0 && v) begin
        if (k < NN) begin ewx = 1; lxa = 12'(k); lxd = d; end
        else begin ewy = 1; lya = 12'(k - NN); lyd = d; end
        k++;
        if (k == 2 * NN) ph = 1;
      end else if (ph == 1) ph = 2;
      else if (ph == 2 && dn && !pdone) begin ph = 0; k = 0; pairs++; end
      pdone = dn;
    end
    if (mm_start === 1'b1) starts++;
    chk("x_wr_en", x_wr_en, ewx);
    chk("x_addr", x_addr, lxa);
    chk("x_din", x_din, lxd);
    chk("y_wr_en", y_wr_en, ewy);
    chk("y_addr", y_addr, lya);
    chk("y_din", y_din, lyd);
    chk("mm_start", mm_start, ph == 1);
    chk("in_ready", in_ready, ph == 0);
    chk("busy", busy, ph != 0);
    chk("pair_count", pair_count, 16'(pairs));
  endtask

  task automatic finish_pair();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
  endtask

  initial begin
    int xc, yc, yok, bs;
    logic [11:0] lastx;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_pairs", pair_count, 0);
    for (int i = 0; i < 2 * NN; i++) step(1, 32'h100 + i, 0, 0);
    chk("start_with_y15", {mm_start, y_wr_en, y_addr, y_din}, {1'b1, 1'b1, 12'd15, 32'h11F});
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("still_waiting", in_ready, 0);
    step(0, 0, 1, 0);
    chk("pairs_1", pair_count, 1);
    chk("ready_back", in_ready, 1);
    for (int i = 0; i < 400 && ph == 0; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0);
    chk("random_load_start", mm_start, 1);
    finish_pair();
    for (int i = 0; i < NN + 7; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 1);
    chk("rst_outputs", {x_wr_en, y_wr_en, x_addr, y_addr, x_din, y_din, mm_start, busy, pair_count},
        {1'b0, 1'b0, 12'd0, 12'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0});
    starts = 0;
    for (int i = 0; i < 2 * NN; i++) step(1, $urandom, 1'(i == 20), 0);
    chk("one_start_after_reset", starts, 1);
    finish_pair();
    step(0, 0, 0, 1);
    starts = 0;
    for (int p = 0; p < 2; p++) begin
      step(1, $urandom, 0, 0);
      chk("x_first_addr0", {x_wr_en, x_addr}, {1'b1, 12'd0});
      for (int i = 1; i < 2 * NN; i++) step(1, $urandom, 0, 0);
      finish_pair();
    end
    chk("b2b_starts", starts, 2);
    chk("b2b_pairs", pair_count, 2);
    xc = 0; yc = 0; yok = 0; bs = 0; lastx = 0;
    b_valid = 1;
    for (int i = 0; i < 8192 + 3; i++) begin
      b_din = i;
      @(posedge clock); #1;
      if (b_x_wr_en) begin xc++; lastx = b_x_addr; end
      if (b_y_wr_en) begin if (b_y_addr == 12'(yc)) yok++; yc++; end
      if (b_start) bs++;
    end
    b_valid = 0;
    chk("big_x_count", xc, 4096);
    chk("big_last_x", lastx, 12'hFFF);
    chk("big_y_count", yc, 4096);
    chk("big_y_seq", yok, 4096);
    chk("big_starts", bs, 1);
    chk("big_busy", b_busy, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
- Upstream feeder for the matrix-multiply engine.
- Accepts a valid/ready word stream and writes one VECTOR_SIZE x VECTOR_SIZE matrix into the X BRAM, then one into the Y BRAM, both row-major.
- Pulses the engine's start, then waits for the engine's done before accepting the next matrix pair.
- Sits between the host/DMA stream and the X/Y BRAM write ports plus the engine's start/done pins.

Parameters:
- DATA_WIDTH, 32, width of stream words and BRAM data.
- ADDR_WIDTH, 12, BRAM address width. Requires VECTOR_SIZE*VECTOR_SIZE <= 2**ADDR_WIDTH.
- VECTOR_SIZE, 64, matrix dimension N. Each matrix is N*N words.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_din  in  DATA_WIDTH  stream data word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word this cycle.
- x_din  out  DATA_WIDTH  X BRAM write data.
- x_addr  out  ADDR_WIDTH  X BRAM write address.
- x_wr_en  out  1  X BRAM write enable.
- y_din  out  DATA_WIDTH  Y BRAM write data.
- y_addr  out  ADDR_WIDTH  Y BRAM write address.
- y_wr_en  out  1  Y BRAM write enable.
- mm_start  out  1  one-cycle start pulse to the engine.
- mm_done  in  1  engine done level. Low while computing; held high after completion until the next start.
- busy  out  1  high in START and WAIT.
- pair_count  out  16  number of completed multiplies, wraps at 2**16.

Behaviour:
- States:
  - LOAD_X: in_ready=1.
  - LOAD_Y: in_ready=1.
  - START: in_ready=0, mm_start=1.
  - WAIT: in_ready=0.
- in_ready and busy are combinational from state only. in_ready does not depend on in_valid.
- A word is accepted when in_valid && in_ready.
- Word counter cnt (ADDR_WIDTH bits) resets to 0.
- LOAD_X, on accept:
  - Next cycle: x_wr_en=1, x_addr=cnt, x_din=in_din. These outputs are registered, giving 1-cycle write latency.
  - If cnt==N*N-1: cnt<=0 and go to LOAD_Y. Otherwise cnt<=cnt+1.
- LOAD_Y: same rules driving y_*. Accepting the last word (cnt==N*N-1) goes to START.
- x_wr_en/y_wr_en are 0 in any cycle following a non-accept. x_addr/x_din and y_addr/y_din hold their last values when not writing.
- in_valid low stalls the counter without penalty. Gaps are allowed anywhere.
- START lasts exactly one cycle with mm_start=1, then goes to WAIT. The final Y write (registered) occurs in the same cycle as mm_start, before the engine issues its first read.
- Done edge detection:
  - done_q <= mm_done every cycle; reset value 0.
  - WAIT exits to LOAD_X when mm_done && !done_q (rising edge). At that edge, pair_count <= pair_count+1.
  - A stale high mm_done from the previous run never ends WAIT. Only a new rising edge does.
- The first accepted word after a return to LOAD_X is written to x_addr=0.
- Reset values: in_ready=1 (state LOAD_X), busy=0, all wr_en=0, all addr/din=0, mm_start=0, pair_count=0, cnt=0, done_q=0.
- Reset mid-operation (any state) returns to LOAD_X with cnt=0 and discards the partial matrix.
  - Any write registered for the reset cycle is suppressed.
  - mm_start is never asserted for a partial load.
- mm_done rising while in LOAD_X/LOAD_Y/START is ignored for state purposes and does not change pair_count. done_q still tracks it.

Test Plan:
- VECTOR_SIZE=4. Reset, then stream 32 words 0x100..0x11F with in_valid held 1:
  - 16 X writes at addr 0..15 with data 0x100..0x10F.
  - 16 Y writes at addr 0..15 with data 0x110..0x11F.
  - mm_start=1 for exactly one cycle, coincident with the Y addr-15 write.
  - in_ready=0 from then on.
- In WAIT, hold mm_done=1 (stale) for 5 cycles, then 0 for 3 cycles, then 1:
  - State leaves WAIT one cycle after the rise.
  - pair_count 0->1.
  - in_ready returns to 1.
- Toggle in_valid 1,0,0,1 randomly across a full load:
  - Write addresses stay contiguous 0..15 per matrix.
  - No write occurs in cycles after a non-accept.
  - Data order is preserved.
- Assert reset for 1 cycle after the 7th Y word:
  - No write the next cycle.
  - Outputs return to reset values.
  - The next stream of 32 words loads X starting at addr 0.
  - mm_start is not pulsed before those 32 words complete.
- Run two back-to-back full pairs:
  - The second X load begins at addr 0.
  - pair_count=2 at the end.
  - mm_start pulses exactly twice.
- Default VECTOR_SIZE=64, stream 8192 words:
  - Last X write at addr 0xFFF.
  - Y addresses cover 0x000..0xFFF.
  - Exactly one mm_start.
